// File: rtl/cache_lru_tracker_pkg.sv
// Shared sizing, types and reset helper for the per-set true-LRU tracker.
// Ages run 0 (MRU) .. WAYS-1 (LRU), and within a set they always form a permutation.
package cache_lru_tracker_pkg;

    localparam int WAYS       = 4;
    localparam int TOTAL_SIZE = 16;
    localparam int SETS       = TOTAL_SIZE / WAYS;
    localparam int SET_W      = $clog2(SETS);
    localparam int WAY_W      = $clog2(WAYS);

    typedef logic [WAY_W-1:0] age_t;
    typedef logic [WAY_W-1:0] way_t;
    typedef logic [SET_W-1:0] set_idx_t;
    typedef age_t [WAYS-1:0]  age_vec_t;

    typedef enum logic [0:0] {
        LRU_IDLE,
        LRU_FLUSH
    } lru_state_e;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_UPD,
        OP_INV,
        OP_RST
    } lru_op_e;

    // Way 0 starts as LRU, so a freshly reset set fills in order 0,1,2,...
    function automatic age_vec_t reset_ages();
        age_vec_t v;
        for (int w = 0; w < WAYS; w++) begin
            v[w] = age_t'(WAYS - 1 - w);
        end
        return v;
    endfunction

endpackage

// File: rtl/cache_lru_tracker_if.sv
// Bundle between the hit/way-select stage (master) and the LRU tracker (slave).
// Handshake: a request with *_valid high is accepted on a rising edge where *_ready is also high;
// the requester holds valid and its payload stable until that edge, and ready may depend on valid.
interface cache_lru_tracker_if;
    import cache_lru_tracker_pkg::*;

    set_idx_t rd_set;
    way_t     lru_way;

    logic     upd_valid;
    set_idx_t upd_set;
    way_t     upd_way;
    logic     upd_ready;

    logic     inv_valid;
    set_idx_t inv_set;
    way_t     inv_way;
    logic     inv_ready;

    logic     flush_req;
    logic     flush_busy;
    logic     flush_done;

    modport master (
        output rd_set, upd_valid, upd_set, upd_way, inv_valid, inv_set, inv_way, flush_req,
        input  lru_way, upd_ready, inv_ready, flush_busy, flush_done
    );

    modport slave (
        input  rd_set, upd_valid, upd_set, upd_way, inv_valid, inv_set, inv_way, flush_req,
        output lru_way, upd_ready, inv_ready, flush_busy, flush_done
    );

endinterface

// File: rtl/cache_lru_tracker_set_next.sv
// Combinational next-age computation for one set, plus the LRU way of the current ages.
module cache_lru_tracker_set_next
    import cache_lru_tracker_pkg::*;
(
    input  age_vec_t ages_i,
    input  lru_op_e  op_i,
    input  way_t     way_i,
    output age_vec_t ages_o,
    output way_t     lru_way_o
);

    age_t ref_age;

    // Touching the MRU way (or invalidating the LRU way) leaves every other age untouched.
    always_comb begin
        ref_age = ages_i[way_i];
        ages_o  = ages_i;
        case (op_i)
            OP_UPD: begin
                for (int w = 0; w < WAYS; w++) begin
                    if (way_t'(w) == way_i) begin
                        ages_o[w] = '0;
                    end else if (ages_i[w] < ref_age) begin
                        ages_o[w] = ages_i[w] + age_t'(1);
                    end
                end
            end
            OP_INV: begin
                for (int w = 0; w < WAYS; w++) begin
                    if (way_t'(w) == way_i) begin
                        ages_o[w] = age_t'(WAYS - 1);
                    end else if (ages_i[w] > ref_age) begin
                        ages_o[w] = ages_i[w] - age_t'(1);
                    end
                end
            end
            OP_RST:  ages_o = reset_ages();
            default: ages_o = ages_i;
        endcase
    end

    always_comb begin
        lru_way_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ages_i[w] == age_t'(WAYS - 1)) begin
                lru_way_o = way_t'(w);
            end
        end
    end

endmodule

// File: rtl/cache_lru_tracker.sv
// Per-set true-LRU state: MRU updates, invalidations and a one-set-per-cycle flush walk.
// lru_way for rd_set comes straight from registered ages; accepted requests show up next cycle.
module cache_lru_tracker
    import cache_lru_tracker_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    cache_lru_tracker_if.slave bus,
    output lru_state_e         state_o
);

    lru_state_e state_q, state_d;
    set_idx_t   cnt_q, cnt_d;
    logic       flush_done_q, flush_done_d;

    age_vec_t   ages_q  [SETS];
    age_vec_t   ages_d  [SETS];
    lru_op_e    op      [SETS];
    way_t       op_way  [SETS];
    way_t       set_lru [SETS];

    logic       upd_ready;
    logic       inv_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_done_d = 1'b0;
        case (state_q)
            LRU_IDLE: begin
                if (bus.flush_req) begin
                    state_d = LRU_FLUSH;
                    cnt_d   = '0;
                end
            end
            LRU_FLUSH: begin
                cnt_d = cnt_q + set_idx_t'(1);
                if (cnt_q == set_idx_t'(SETS - 1)) begin
                    state_d      = LRU_IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = LRU_IDLE;
        endcase
    end

    // An invalidate and an update to the same set would race on one age vector; the invalidate wins.
    assign inv_ready = (state_q == LRU_IDLE);
    assign upd_ready = inv_ready && !(bus.inv_valid && (bus.inv_set == bus.upd_set));

    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            op[s]     = OP_NONE;
            op_way[s] = '0;
            if (state_q == LRU_FLUSH) begin
                if (cnt_q == set_idx_t'(s)) begin
                    op[s] = OP_RST;
                end
            end else if (bus.inv_valid && (bus.inv_set == set_idx_t'(s))) begin
                op[s]     = OP_INV;
                op_way[s] = bus.inv_way;
            end else if (bus.upd_valid && upd_ready && (bus.upd_set == set_idx_t'(s))) begin
                op[s]     = OP_UPD;
                op_way[s] = bus.upd_way;
            end
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_set
        cache_lru_tracker_set_next u_next (
            .ages_i    (ages_q[s]),
            .op_i      (op[s]),
            .way_i     (op_way[s]),
            .ages_o    (ages_d[s]),
            .lru_way_o (set_lru[s])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LRU_IDLE;
            cnt_q        <= '0;
            flush_done_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                ages_q[s] <= reset_ages();
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_done_q <= flush_done_d;
            for (int s = 0; s < SETS; s++) begin
                ages_q[s] <= ages_d[s];
            end
        end
    end

    // The read port reuses each set's own LRU decode rather than a separate lookup of rd_set.
    assign bus.lru_way    = set_lru[bus.rd_set];
    assign bus.upd_ready  = upd_ready;
    assign bus.inv_ready  = inv_ready;
    assign bus.flush_busy = (state_q == LRU_FLUSH);
    assign bus.flush_done = flush_done_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_cache_lru_tracker.sv
// Self-checking bench for cache_lru_tracker with a recency-list reference model per set.
module tb_cache_lru_tracker;
    import cache_lru_tracker_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    lru_state_e state_o;

    cache_lru_tracker_if bus();

    cache_lru_tracker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    int               order_q [SETS][$];   // per set: ways from MRU (front) to LRU (back)
    logic [WAY_W-1:0] exp_q [$];
    logic [WAY_W-1:0] exp_v;
    bit               mon_en = 1'b0;
    age_vec_t         mon_exp;
    logic [WAYS-1:0]  mon_seen;

    function automatic int m_find(int s, int w);
        for (int i = 0; i < order_q[s].size(); i++) begin
            if (order_q[s][i] == w) return i;
        end
        return -1;
    endfunction

    function automatic void m_reset_set(int s);
        order_q[s].delete();
        for (int w = WAYS - 1; w >= 0; w--) order_q[s].push_back(w);
    endfunction

    function automatic void m_touch(int s, int w);
        order_q[s].delete(m_find(s, w));
        order_q[s].push_front(w);
    endfunction

    function automatic void m_inv(int s, int w);
        order_q[s].delete(m_find(s, w));
        order_q[s].push_back(w);
    endfunction

    function automatic int m_lru(int s);
        return order_q[s][order_q[s].size() - 1];
    endfunction

    // Every cycle: each set's ages must be a permutation and match the model's list positions.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < SETS; s++) begin
                mon_seen = '0;
                for (int w = 0; w < WAYS; w++) begin
                    mon_seen[dut.ages_q[s][w]] = 1'b1;
                    mon_exp[w] = age_t'(m_find(s, w));
                end
                checks++;
                if (mon_seen !== '1) begin
                    errors++;
                    $display("FAIL perm set%0d t=%0t ages=%h required a permutation", s, $time, dut.ages_q[s]);
                end
                checks++;
                if (dut.ages_q[s] !== mon_exp) begin
                    errors++;
                    $display("FAIL ages set%0d t=%0t got %h expected %h", s, $time, dut.ages_q[s], mon_exp);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.upd_valid = 1'b0;
        bus.upd_set   = '0;
        bus.upd_way   = '0;
        bus.inv_valid = 1'b0;
        bus.inv_set   = '0;
        bus.inv_way   = '0;
        bus.flush_req = 1'b0;
    endtask

    task automatic drive_upd(input int s, input int w);
        bus.upd_valid = 1'b1;
        bus.upd_set   = set_idx_t'(s);
        bus.upd_way   = way_t'(w);
    endtask

    task automatic drive_inv(input int s, input int w);
        bus.inv_valid = 1'b1;
        bus.inv_set   = set_idx_t'(s);
        bus.inv_way   = way_t'(w);
    endtask

    // Advance one rising edge and apply to the model what the bench expects the DUT to accept.
    task automatic edge_apply(input bit do_upd, input bit do_inv, input int flush_set);
        @(posedge clk);
        if (do_inv) m_inv(int'(bus.inv_set), int'(bus.inv_way));
        if (do_upd) m_touch(int'(bus.upd_set), int'(bus.upd_way));
        if (flush_set >= 0) m_reset_set(flush_set);
        #1;
    endtask

    // Present rd_set, queue the expected lru_way, and wait for the sampling point (no edge passes).
    task automatic sb_expect(input int s);
        bus.rd_set = set_idx_t'(s);
        exp_q.push_back(way_t'(m_lru(s)));
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b0 || state_o !== LRU_IDLE) begin
            errors++;
            $display("FAIL reset_status busy=%b done=%b state=%0d expected 0 0 0", bus.flush_busy, bus.flush_done, state_o);
        end
        checks++;
        if (bus.upd_ready !== 1'b1 || bus.inv_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready upd=%b inv=%b expected 1 1", bus.upd_ready, bus.inv_ready);
        end
        for (int s = 0; s < SETS; s++) begin
            sb_expect(s);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.lru_way !== exp_v || bus.lru_way !== '0) begin
                errors++;
                $display("FAIL reset_lru set%0d got %0d expected %0d", s, bus.lru_way, exp_v);
            end
        end
    endtask

    task automatic test_update();
        for (int w = 0; w < WAYS; w++) begin
            drive_upd(1, w);
            bus.rd_set = set_idx_t'(1);
            exp_q.push_back(way_t'(m_lru(1)));
            #1;
            checks++;
            if (bus.upd_ready !== 1'b1) begin
                errors++;
                $display("FAIL upd_ready way%0d got %b expected 1", w, bus.upd_ready);
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.lru_way !== exp_v) begin
                errors++;
                $display("FAIL upd_no_bypass way%0d got %0d expected %0d", w, bus.lru_way, exp_v);
            end
            edge_apply(1'b1, 1'b0, -1);
            idle_inputs();
            sb_expect(1);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.lru_way !== exp_v) begin
                errors++;
                $display("FAIL upd_lru after way%0d got %0d expected %0d", w, bus.lru_way, exp_v);
            end
        end
    endtask

    task automatic test_invalidate();
        for (int w = WAYS - 1; w >= 0; w--) begin
            drive_upd(2, w);
            edge_apply(1'b1, 1'b0, -1);
        end
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            drive_inv(2, 1);
            #1;
            checks++;
            if (bus.inv_ready !== 1'b1) begin
                errors++;
                $display("FAIL inv_ready pass%0d got %b expected 1", k, bus.inv_ready);
            end
            edge_apply(1'b0, 1'b1, -1);
            idle_inputs();
            sb_expect(2);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.lru_way !== exp_v || bus.lru_way !== way_t'(1)) begin
                errors++;
                $display("FAIL inv_lru pass%0d got %0d expected %0d", k, bus.lru_way, exp_v);
            end
        end
    endtask

    task automatic test_arbitration();
        drive_inv(0, 2);
        drive_upd(0, 0);
        #1;
        checks++;
        if (bus.upd_ready !== 1'b0 || bus.inv_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_set_ready upd=%b inv=%b expected 0 1", bus.upd_ready, bus.inv_ready);
        end
        edge_apply(1'b0, 1'b1, -1);
        bus.inv_valid = 1'b0;
        #1;
        checks++;
        if (bus.upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL held_upd_ready got %b expected 1", bus.upd_ready);
        end
        edge_apply(1'b1, 1'b0, -1);
        idle_inputs();
        sb_expect(0);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.lru_way !== exp_v) begin
            errors++;
            $display("FAIL same_set_lru got %0d expected %0d", bus.lru_way, exp_v);
        end

        drive_inv(0, 1);
        drive_upd(3, 2);
        #1;
        checks++;
        if (bus.upd_ready !== 1'b1 || bus.inv_ready !== 1'b1) begin
            errors++;
            $display("FAIL diff_set_ready upd=%b inv=%b expected 1 1", bus.upd_ready, bus.inv_ready);
        end
        edge_apply(1'b1, 1'b1, -1);
        idle_inputs();
        for (int s = 0; s < SETS; s += 3) begin
            sb_expect(s);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.lru_way !== exp_v) begin
                errors++;
                $display("FAIL diff_set_lru set%0d got %0d expected %0d", s, bus.lru_way, exp_v);
            end
        end
    endtask

    task automatic test_flush();
        int done_pulses;
        done_pulses = 0;
        for (int pass = 0; pass < 2; pass++) begin
            bus.flush_req = 1'b1;
            edge_apply(1'b0, 1'b0, -1);
            bus.flush_req = 1'b0;
            for (int k = 0; k < SETS; k++) begin
                drive_upd(k, 1);
                drive_inv((k + 1) % SETS, 0);
                if (k == 2) bus.flush_req = 1'b1;
                #1;
                checks++;
                if (bus.flush_busy !== 1'b1 || bus.upd_ready !== 1'b0 || bus.inv_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_cycle p%0d k%0d busy=%b upd=%b inv=%b expected 1 0 0",
                             pass, k, bus.flush_busy, bus.upd_ready, bus.inv_ready);
                end
                if (bus.flush_done === 1'b1) done_pulses++;
                edge_apply(1'b0, 1'b0, k);
                bus.flush_req = 1'b0;
            end
            idle_inputs();
            checks++;
            if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b1 || state_o !== LRU_IDLE) begin
                errors++;
                $display("FAIL flush_end p%0d busy=%b done=%b state=%0d expected 0 1 0",
                         pass, bus.flush_busy, bus.flush_done, state_o);
            end
            if (bus.flush_done === 1'b1) done_pulses++;
        end
        edge_apply(1'b0, 1'b0, -1);
        checks++;
        if (bus.flush_done !== 1'b0 || bus.flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_after done=%b busy=%b expected 0 0", bus.flush_done, bus.flush_busy);
        end
        checks++;
        if (done_pulses != 2) begin
            errors++;
            $display("FAIL flush_done_count got %0d expected 2", done_pulses);
        end
        for (int s = 0; s < SETS; s++) begin
            sb_expect(s);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.lru_way !== exp_v) begin
                errors++;
                $display("FAIL flush_lru set%0d got %0d expected %0d", s, bus.lru_way, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        for (int s = 2; s < SETS; s++) begin
            drive_upd(s, s - 2);
            edge_apply(1'b1, 1'b0, -1);
        end
        idle_inputs();
        bus.flush_req = 1'b1;
        edge_apply(1'b0, 1'b0, -1);
        bus.flush_req = 1'b0;
        edge_apply(1'b0, 1'b0, 0);
        rst_n = 1'b0;
        for (int s = 0; s < SETS; s++) m_reset_set(s);
        #1;
        checks++;
        if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b0 || state_o !== LRU_IDLE) begin
            errors++;
            $display("FAIL mid_flush_reset busy=%b done=%b state=%0d expected 0 0 0",
                     bus.flush_busy, bus.flush_done, state_o);
        end
        edge_apply(1'b0, 1'b0, -1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < SETS; c++) begin
            @(negedge clk);
            checks++;
            if (bus.flush_done !== 1'b0 || bus.flush_busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset c%0d done=%b busy=%b expected 0 0", c, bus.flush_done, bus.flush_busy);
            end
        end
        for (int s = 0; s < SETS; s++) begin
            sb_expect(s);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.lru_way !== exp_v) begin
                errors++;
                $display("FAIL post_reset_lru set%0d got %0d expected %0d", s, bus.lru_way, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.rd_set = '0;
        for (int s = 0; s < SETS; s++) m_reset_set(s);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        test_reset();
        test_update();
        test_invalidate();
        test_arbitration();
        test_flush();
        test_reset_mid_flush();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
